// File: rtl/uart_pkg.sv
// Shared definitions for the blackjack UART receive path.
//
// Frame layout: byte index 0 carries the status flags and byte indices
// 1..N_CARDS carry one dealer card each. Every byte is {value[7:4], index[3:0]}.
// The status byte is {0, start, deal, dealer_finished, 4'h0}.
package uart_pkg;

  localparam int N_CARDS = 9;   // dealer card slots per frame
  localparam int VAL_W   = 4;   // card value width, byte bits [7:4]
  localparam int IDX_W   = 4;   // slot index width, byte bits [3:0]

  localparam logic [IDX_W-1:0] IDX_STATUS = 4'h0;
  localparam logic [IDX_W-1:0] FIRST_CARD = 4'h1;
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N_CARDS);

  typedef logic [VAL_W-1:0] card_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_POP    = 2'd1,
    S_DECODE = 2'd2
  } uart_dec_state_t;

endpackage

// File: rtl/uart_rx_fetch.sv
// RX FIFO pop handshake for uart_decoder.
//
// Waits in S_IDLE for a non-empty FIFO, captures the head byte, pulses the
// pop strobe for one cycle (S_POP) so the FIFO can update its empty flag, and
// then presents the captured byte for one cycle (S_DECODE) to the frame
// checker. The FIFO is only sampled in S_IDLE, so one byte takes 3 clocks.
//
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   rx_empty   FIFO empty flag; r_data valid when 0
//   r_data     FIFO head byte
//   rd_uart    FIFO pop strobe, high for the one S_POP cycle
//   byte_q     captured byte, stable from S_POP through S_DECODE
//   byte_vld   high for the one S_DECODE cycle
module uart_rx_fetch
  import uart_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_empty,
  input  logic [7:0] r_data,
  output logic       rd_uart,
  output logic [7:0] byte_q,
  output logic       byte_vld
);

  uart_dec_state_t state_q, state_d;
  logic            rd_uart_q, rd_uart_d;
  logic            load;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      rd_uart_q <= 1'b0;
      byte_q    <= 8'h00;
    end else begin
      state_q   <= state_d;
      rd_uart_q <= rd_uart_d;
      if (load) byte_q <= r_data;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (!rx_empty) state_d = S_POP;
      S_POP:    state_d = S_DECODE;
      S_DECODE: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output logic: the pop strobe is registered so it lands in the S_POP cycle
  always_comb begin
    load      = (state_q == S_IDLE) && !rx_empty;
    rd_uart_d = load;
    byte_vld  = (state_q == S_DECODE);
  end

  assign rd_uart = rd_uart_q;

endmodule

// File: rtl/uart_decoder.sv
// Receive-side frame decoder for the blackjack UART link.
//
// Pops bytes from the RX FIFO (through uart_rx_fetch) and assembles the
// 10-byte frame: one status byte followed by dealer cards 1..N_CARDS in order.
// Bytes accumulate in shadow registers; only a complete in-order frame is
// copied to the committed outputs, which the player-side logic treats as the
// remote board state.
//
// Optional feature: define UART_DECODER_ERRCNT_EN to build a saturating 8-bit
// count of frame_error pulses on err_count. Without it err_count is 8'h00.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   rx_empty, r_data    RX FIFO empty flag and head byte
//   rd_uart             RX FIFO pop strobe (1-cycle pulse)
//   start               committed status bit 6
//   deal                committed status bit 5
//   dealer_finished     committed status bit 4
//   dealer_card_values  committed cards, slot k from byte index k+1
//   frame_valid         1-cycle pulse when a frame is committed
//   frame_error         1-cycle pulse when a byte/frame is discarded
//   err_count           sequence-error count (0 unless the counter is built)
module uart_decoder
  import uart_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rx_empty,
  input  logic [7:0]               r_data,
  output logic                     rd_uart,
  output logic                     start,
  output logic                     deal,
  output logic                     dealer_finished,
  output logic [N_CARDS*VAL_W-1:0] dealer_card_values,
  output logic                     frame_valid,
  output logic                     frame_error,
  output logic [7:0]               err_count
);

  logic [7:0] byte_q;
  logic       byte_vld;

  uart_rx_fetch u_fetch (
    .clk      (clk),
    .rst      (rst),
    .rx_empty (rx_empty),
    .r_data   (r_data),
    .rd_uart  (rd_uart),
    .byte_q   (byte_q),
    .byte_vld (byte_vld)
  );

  logic [IDX_W-1:0]         exp_idx_q, exp_idx_d;
  logic [2:0]               flags_q, flags_d;
  card_t                    shadow_q [N_CARDS];
  card_t                    shadow_d [N_CARDS];
  logic [2:0]               out_flags_q, out_flags_d;
  logic [N_CARDS*VAL_W-1:0] cards_q, cards_d;
  logic                     fv_q, fv_d;
  logic                     fe_q, fe_d;

  logic [IDX_W-1:0] idx;
  card_t            val;
  logic             is_status;
  logic             in_order;

  assign idx       = byte_q[IDX_W-1:0];
  assign val       = byte_q[7:4];
  assign is_status = (idx == IDX_STATUS);
  // exp_idx is 0 outside a frame, so a card with no preceding header never matches
  assign in_order  = !is_status && (idx <= LAST_IDX) && (idx == exp_idx_q);

  // Frame check and commit
  always_comb begin
    exp_idx_d   = exp_idx_q;
    flags_d     = flags_q;
    shadow_d    = shadow_q;
    out_flags_d = out_flags_q;
    cards_d     = cards_q;
    fv_d        = 1'b0;
    fe_d        = 1'b0;
    if (byte_vld) begin
      if (is_status) begin
        if (!byte_q[7]) begin
          // A header always restarts the frame, even mid-frame, without error
          flags_d   = byte_q[6:4];
          exp_idx_d = FIRST_CARD;
        end else begin
          fe_d      = 1'b1;
          exp_idx_d = IDX_STATUS;
        end
      end else if (in_order) begin
        shadow_d[idx - FIRST_CARD] = val;
        exp_idx_d = exp_idx_q + FIRST_CARD;
        if (idx == LAST_IDX) begin
          // Commit from shadow_d so the final card lands in the same edge
          for (int k = 0; k < N_CARDS; k++) begin
            cards_d[k*VAL_W +: VAL_W] = shadow_d[k];
          end
          out_flags_d = flags_d;
          fv_d        = 1'b1;
          exp_idx_d   = IDX_STATUS;
        end
      end else begin
        fe_d      = 1'b1;
        exp_idx_d = IDX_STATUS;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      exp_idx_q   <= IDX_STATUS;
      flags_q     <= 3'b000;
      out_flags_q <= 3'b000;
      cards_q     <= '0;
      fv_q        <= 1'b0;
      fe_q        <= 1'b0;
      for (int k = 0; k < N_CARDS; k++) begin
        shadow_q[k] <= '0;
      end
    end else begin
      exp_idx_q   <= exp_idx_d;
      flags_q     <= flags_d;
      out_flags_q <= out_flags_d;
      cards_q     <= cards_d;
      fv_q        <= fv_d;
      fe_q        <= fe_d;
      for (int k = 0; k < N_CARDS; k++) begin
        shadow_q[k] <= shadow_d[k];
      end
    end
  end

  assign start              = out_flags_q[2];
  assign deal               = out_flags_q[1];
  assign dealer_finished    = out_flags_q[0];
  assign dealer_card_values = cards_q;
  assign frame_valid        = fv_q;
  assign frame_error        = fe_q;

`ifdef UART_DECODER_ERRCNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  // Counts on fe_d so the count moves on the same edge the pulse rises
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (fe_d && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) err_cnt_q <= 8'h00;
    else     err_cnt_q <= err_cnt_d;
  end

  assign err_count = err_cnt_q;
`else
  assign err_count = 8'h00;
`endif

endmodule

// File: tb/tb_uart_decoder.sv
module tb_uart_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_empty;
  logic [7:0]  r_data;
  logic        rd_uart;
  logic        start;
  logic        deal;
  logic        dealer_finished;
  logic [35:0] dealer_card_values;
  logic        frame_valid;
  logic        frame_error;
  logic [7:0]  err_count;

  int n_vec = 0;
  int n_err = 0;

  int pop_cnt = 0;
  int fv_cnt  = 0;
  int fe_cnt  = 0;
  bit excl_bad   = 1'b0;
  bit consec_bad = 1'b0;
  bit rd_prev    = 1'b0;

  int pop_base, fv_base, fe_base;
  logic [35:0] held_cards;

  uart_decoder dut (
    .clk                (clk),
    .rst                (rst),
    .rx_empty           (rx_empty),
    .r_data             (r_data),
    .rd_uart            (rd_uart),
    .start              (start),
    .deal               (deal),
    .dealer_finished    (dealer_finished),
    .dealer_card_values (dealer_card_values),
    .frame_valid        (frame_valid),
    .frame_error        (frame_error),
    .err_count          (err_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rd_uart === 1'b1)     pop_cnt <= pop_cnt + 1;
    if (frame_valid === 1'b1) fv_cnt  <= fv_cnt + 1;
    if (frame_error === 1'b1) fe_cnt  <= fe_cnt + 1;
    if (frame_valid === 1'b1 && frame_error === 1'b1) excl_bad <= 1'b1;
    if (rd_uart === 1'b1 && rd_prev) consec_bad <= 1'b1;
    rd_prev <= (rd_uart === 1'b1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit got;
    got      = 1'b0;
    r_data   = b;
    rx_empty = 1'b0;
    for (int t = 0; t < 20 && !got; t++) begin
      @(posedge clk);
      #1;
      if (rd_uart === 1'b1) got = 1'b1;
    end
    if (!got) check("pop_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    rx_empty = 1'b1;
  endtask

  task automatic check_outputs(input string tag, input logic s, input logic d,
                               input logic f, input logic [35:0] c);
    check({tag, "_start"}, 64'(start), 64'(s));
    check({tag, "_deal"},  64'(deal), 64'(d));
    check({tag, "_fin"},   64'(dealer_finished), 64'(f));
    check({tag, "_cards"}, 64'(dealer_card_values), 64'(c));
  endtask

  initial begin
    // Reset with a non-empty FIFO: no pops, all outputs 0
    rst      = 1'b1;
    rx_empty = 1'b0;
    r_data   = 8'h60;
    cycles(1);
    check("rst_rd_uart_c1", 64'(rd_uart), 64'd0);
    cycles(1);
    check("rst_rd_uart_c2", 64'(rd_uart), 64'd0);
    check_outputs("rst", 1'b0, 1'b0, 1'b0, 36'h0);
    check("rst_fv", 64'(frame_valid), 64'd0);
    check("rst_fe", 64'(frame_error), 64'd0);
    check("rst_errcnt", 64'(err_count), 64'd0);
    check("rst_pops", 64'(pop_cnt), 64'd0);
    rx_empty = 1'b1;
    rst      = 1'b0;
    cycles(2);

    // Good frame: status 0x60 then cards 1..9
    pop_base = pop_cnt; fv_base = fv_cnt; fe_base = fe_cnt;
    send_byte(8'h60);
    send_byte(8'hA1);
    send_byte(8'h32);
    send_byte(8'h13);
    send_byte(8'h44);
    send_byte(8'h55);
    send_byte(8'h66);
    send_byte(8'h77);
    check_outputs("partial", 1'b0, 1'b0, 1'b0, 36'h0);
    send_byte(8'h88);
    send_byte(8'h99);
    cycles(4);
    check_outputs("good", 1'b1, 1'b1, 1'b0, 36'h98765413A);
    check("good_fv", 64'(fv_cnt - fv_base), 64'd1);
    check("good_fe", 64'(fe_cnt - fe_base), 64'd0);
    check("good_pops", 64'(pop_cnt - pop_base), 64'd10);
    check("good_errcnt", 64'(err_count), 64'd0);
    held_cards = 36'h98765413A;

    // Out of order: index 3 where 2 was expected
    fv_base = fv_cnt; fe_base = fe_cnt;
    send_byte(8'h40);
    send_byte(8'h51);
    send_byte(8'h73);
    cycles(4);
    check("ooo_fe", 64'(fe_cnt - fe_base), 64'd1);
    check("ooo_fv", 64'(fv_cnt - fv_base), 64'd0);
    check_outputs("ooo", 1'b1, 1'b1, 1'b0, held_cards);
`ifdef UART_DECODER_ERRCNT_EN
    check("ooo_errcnt", 64'(err_count), 64'd1);
`else
    check("ooo_errcnt", 64'(err_count), 64'd0);
`endif

    // Resync: a header mid-frame restarts without error
    fv_base = fv_cnt; fe_base = fe_cnt;
    send_byte(8'h20);
    send_byte(8'h51);
    send_byte(8'h10);
    send_byte(8'h01);
    send_byte(8'h12);
    send_byte(8'h23);
    send_byte(8'h34);
    send_byte(8'h45);
    send_byte(8'h56);
    send_byte(8'h67);
    send_byte(8'h78);
    send_byte(8'h89);
    cycles(4);
    check_outputs("resync", 1'b0, 1'b0, 1'b1, 36'h876543210);
    check("resync_fv", 64'(fv_cnt - fv_base), 64'd1);
    check("resync_fe", 64'(fe_cnt - fe_base), 64'd0);
    held_cards = 36'h876543210;

    // 300 bytes with an out-of-range index: counter saturates
    fv_base = fv_cnt; fe_base = fe_cnt;
    for (int i = 0; i < 300; i++) send_byte(8'h0F);
    cycles(4);
    check("bad_fe", 64'(fe_cnt - fe_base), 64'd300);
    check("bad_fv", 64'(fv_cnt - fv_base), 64'd0);
    check_outputs("bad", 1'b0, 1'b0, 1'b1, held_cards);
`ifdef UART_DECODER_ERRCNT_EN
    check("bad_errcnt", 64'(err_count), 64'hFF);
`else
    check("bad_errcnt", 64'(err_count), 64'h00);
`endif

    // Reset after card 5 discards the partial frame
    send_byte(8'h70);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    send_byte(8'h55);
    cycles(3);
    rst = 1'b1;
    cycles(2);
    rst = 1'b0;
    check_outputs("midrst", 1'b0, 1'b0, 1'b0, 36'h0);
    check("midrst_errcnt", 64'(err_count), 64'd0);
    fv_base = fv_cnt; fe_base = fe_cnt;
    send_byte(8'h16);
    cycles(4);
    check("midrst_fe_b6", 64'(fe_cnt - fe_base), 64'd1);
    send_byte(8'h17);
    send_byte(8'h18);
    send_byte(8'h19);
    cycles(4);
    check("midrst_fe_all", 64'(fe_cnt - fe_base), 64'd4);
    check("midrst_fv", 64'(fv_cnt - fv_base), 64'd0);
    check_outputs("midrst_after", 1'b0, 1'b0, 1'b0, 36'h0);
`ifdef UART_DECODER_ERRCNT_EN
    check("midrst_errcnt_after", 64'(err_count), 64'd4);
`else
    check("midrst_errcnt_after", 64'(err_count), 64'd0);
`endif

    check("pulse_exclusive", 64'(excl_bad), 64'd0);
    check("rd_uart_not_consecutive", 64'(consec_bad), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
